// File: rtl/axi4_ar_arbiter_pkg.sv
// rtl/axi4_ar_arbiter_pkg.sv - shared field layout, FSM state and defaults for the AR arbiter
package axi4_ar_arbiter_pkg;

  // AR payload below the id: {addr[31:0], len[7:0], size[2:0], burst[1:0]}
  localparam int AR_BURST_W   = 2;
  localparam int AR_SIZE_W    = 3;
  localparam int AR_LEN_W     = 8;
  localparam int AR_ADDR_W    = 32;
  localparam int AR_BURST_LSB = 0;
  localparam int AR_SIZE_LSB  = AR_BURST_LSB + AR_BURST_W;
  localparam int AR_LEN_LSB   = AR_SIZE_LSB + AR_SIZE_W;
  localparam int AR_ADDR_LSB  = AR_LEN_LSB + AR_LEN_W;
  localparam int AR_ID_LSB    = AR_ADDR_LSB + AR_ADDR_W;

  // R payload below the id: {data[63:0], resp[1:0], last}
  localparam int R_LAST_LSB = 0;
  localparam int R_RESP_W   = 2;
  localparam int R_DATA_W   = 64;
  localparam int R_RESP_LSB = R_LAST_LSB + 1;
  localparam int R_DATA_LSB = R_RESP_LSB + R_RESP_W;
  localparam int R_ID_LSB   = R_DATA_LSB + R_DATA_W;

  localparam int CNT_W           = 4;
  localparam int MAX_OUT_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axi4_ar_arbiter_flight_cnt.sv
// rtl/axi4_ar_arbiter_flight_cnt.sv - per-port in-flight read burst counter
module axi4_flight_cnt
  import axi4_ar_arbiter_pkg::*;
#(
  parameter int MAX_OUT = MAX_OUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic at_max
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] r_count;

  assign at_max = (r_count >= MAX_CNT);

  // Simultaneous inc and dec cancel; the edges are guarded so the count never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && !dec && !at_max) begin
      r_count <= r_count + 4'd1;
    end else if (dec && !inc && (r_count != '0)) begin
      r_count <= r_count - 4'd1;
    end
  end

endmodule

// File: rtl/axi4_ar_arbiter.sv
// rtl/axi4_ar_arbiter.sv - two-port AXI4 read-address arbiter with per-port
// outstanding limit and zero-latency R demux on the upper ID bit
module axi4_ar_arbiter
  import axi4_ar_arbiter_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int MAX_OUT = MAX_OUT_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     s0_ar_valid,
  output logic                     s0_ar_ready,
  input  logic [ID_W+AR_ID_LSB-1:0] s0_ar_bits,
  input  logic                     s1_ar_valid,
  output logic                     s1_ar_ready,
  input  logic [ID_W+AR_ID_LSB-1:0] s1_ar_bits,
  output logic                     m_ar_valid,
  input  logic                     m_ar_ready,
  output logic [ID_W+AR_ID_LSB:0]   m_ar_bits,
  input  logic                     m_r_valid,
  output logic                     m_r_ready,
  input  logic [ID_W+R_ID_LSB:0]    m_r_bits,
  output logic                     s0_r_valid,
  input  logic                     s0_r_ready,
  output logic [ID_W+R_ID_LSB-1:0]  s0_r_bits,
  output logic                     s1_r_valid,
  input  logic                     s1_r_ready,
  output logic [ID_W+R_ID_LSB-1:0]  s1_r_bits
);

  localparam int AR_W = ID_W + AR_ID_LSB;
  localparam int R_W  = ID_W + R_ID_LSB;

  arb_state_e      r_state;
  logic            r_last_grant;
  logic            r_hold_port;
  logic [AR_W-1:0] r_hold_bits;

  logic w_at_max0, w_at_max1;
  logic w_elig0, w_elig1;
  logic w_sel_valid, w_sel_port;
  logic w_grant_valid, w_grant_port;
  logic w_ar_fire;
  logic w_r_port, w_r_last_fire;
  logic [AR_W-1:0] w_sel_bits;

  assign w_elig0     = s0_ar_valid & ~w_at_max0;
  assign w_elig1     = s1_ar_valid & ~w_at_max1;
  assign w_sel_valid = w_elig0 | w_elig1;
  // With both eligible, the port that did not win last time goes first.
  assign w_sel_port  = (w_elig0 & w_elig1) ? ~r_last_grant : w_elig1;
  assign w_sel_bits  = w_sel_port ? s1_ar_bits : s0_ar_bits;

  assign w_grant_valid = ~reset & ((r_state == HOLD) | w_sel_valid);
  assign w_grant_port  = (r_state == HOLD) ? r_hold_port : w_sel_port;
  assign w_ar_fire     = w_grant_valid & m_ar_ready;

  assign m_ar_valid  = w_grant_valid;
  assign m_ar_bits   = (r_state == HOLD) ? {r_hold_port, r_hold_bits} : {w_sel_port, w_sel_bits};
  assign s0_ar_ready = m_ar_ready & w_grant_valid & ~w_grant_port;
  assign s1_ar_ready = m_ar_ready & w_grant_valid & w_grant_port;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_hold_port  <= 1'b0;
      r_hold_bits  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sel_valid && !m_ar_ready) begin
            r_state     <= HOLD;
            r_hold_port <= w_sel_port;
            r_hold_bits <= w_sel_bits;
          end
        end
        HOLD: begin
          if (m_ar_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_ar_fire) begin
        r_last_grant <= w_grant_port;
      end
    end
  end

  assign w_r_port      = m_r_bits[ID_W+R_ID_LSB];
  assign s0_r_valid    = m_r_valid & ~w_r_port;
  assign s1_r_valid    = m_r_valid & w_r_port;
  assign s0_r_bits     = m_r_bits[R_W-1:0];
  assign s1_r_bits     = m_r_bits[R_W-1:0];
  assign m_r_ready     = w_r_port ? s1_r_ready : s0_r_ready;
  assign w_r_last_fire = m_r_valid & m_r_ready & m_r_bits[R_LAST_LSB];

  axi4_flight_cnt #(.MAX_OUT(MAX_OUT)) u_cnt0 (
    .clock  (clock),
    .reset  (reset),
    .inc    (w_ar_fire & ~w_grant_port),
    .dec    (w_r_last_fire & ~w_r_port),
    .at_max (w_at_max0)
  );

  axi4_flight_cnt #(.MAX_OUT(MAX_OUT)) u_cnt1 (
    .clock  (clock),
    .reset  (reset),
    .inc    (w_ar_fire & w_grant_port),
    .dec    (w_r_last_fire & w_r_port),
    .at_max (w_at_max1)
  );

endmodule

// File: tb/tb_axi4_ar_arbiter.sv
// tb/tb_axi4_ar_arbiter.sv - directed self-checking bench for axi4_ar_arbiter
module tb_axi4_ar_arbiter;

  localparam int ID_W = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        s0_ar_valid, s0_ar_ready, s1_ar_valid, s1_ar_ready;
  logic [48:0] s0_ar_bits, s1_ar_bits;
  logic        m_ar_valid, m_ar_ready;
  logic [49:0] m_ar_bits;
  logic        m_r_valid, m_r_ready;
  logic [71:0] m_r_bits;
  logic        s0_r_valid, s0_r_ready, s1_r_valid, s1_r_ready;
  logic [70:0] s0_r_bits, s1_r_bits;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  axi4_ar_arbiter #(.ID_W(ID_W), .MAX_OUT(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .s0_ar_valid (s0_ar_valid),
    .s0_ar_ready (s0_ar_ready),
    .s0_ar_bits  (s0_ar_bits),
    .s1_ar_valid (s1_ar_valid),
    .s1_ar_ready (s1_ar_ready),
    .s1_ar_bits  (s1_ar_bits),
    .m_ar_valid  (m_ar_valid),
    .m_ar_ready  (m_ar_ready),
    .m_ar_bits   (m_ar_bits),
    .m_r_valid   (m_r_valid),
    .m_r_ready   (m_r_ready),
    .m_r_bits    (m_r_bits),
    .s0_r_valid  (s0_r_valid),
    .s0_r_ready  (s0_r_ready),
    .s0_r_bits   (s0_r_bits),
    .s1_r_valid  (s1_r_valid),
    .s1_r_ready  (s1_r_ready),
    .s1_r_bits   (s1_r_bits)
  );

  function automatic logic [48:0] ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    return {id, addr, len, 3'd3, 2'd1};
  endfunction

  task automatic idle_inputs();
    s0_ar_valid = 1'b0; s1_ar_valid = 1'b0;
    s0_ar_bits = '0; s1_ar_bits = '0;
    m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_bits = '0;
    s0_r_ready = 1'b0; s1_r_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    s0_ar_valid = 1'b1; s1_ar_valid = 1'b1; m_ar_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (m_ar_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_ar_valid: got %b want 0", m_ar_valid); end
    n_cmp++; if (s0_ar_ready !== 1'b0) begin n_err++; $display("FAIL reset_s0_ar_ready: got %b want 0", s0_ar_ready); end
    n_cmp++; if (s1_ar_ready !== 1'b0) begin n_err++; $display("FAIL reset_s1_ar_ready: got %b want 0", s1_ar_ready); end
    n_cmp++; if (dut.u_cnt0.r_count !== 4'd0) begin n_err++; $display("FAIL reset_cnt0: got %0d want 0", dut.u_cnt0.r_count); end
    n_cmp++; if (dut.u_cnt1.r_count !== 4'd0) begin n_err++; $display("FAIL reset_cnt1: got %0d want 0", dut.u_cnt1.r_count); end
    step();
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic e;
    do_reset();
    s0_ar_bits = ar(4'h1, 32'h0000_0100, 8'd0);
    s1_ar_bits = ar(4'h2, 32'h0000_0200, 8'd1);
    s0_ar_valid = 1'b1; s1_ar_valid = 1'b1; m_ar_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = 1'(i % 2);
      @(negedge clock);
      n_cmp++; if (m_ar_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b want 1", i, m_ar_valid); end
      n_cmp++; if (m_ar_bits[49] !== e) begin n_err++; $display("FAIL rr_port[%0d]: got %b want %b", i, m_ar_bits[49], e); end
      n_cmp++; if (m_ar_bits[48:0] !== (e ? s1_ar_bits : s0_ar_bits)) begin n_err++; $display("FAIL rr_payload[%0d]: got %h", i, m_ar_bits); end
      n_cmp++; if ({s1_ar_ready, s0_ar_ready} !== (e ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", i, {s1_ar_ready, s0_ar_ready}, (e ? 2'b10 : 2'b01)); end
      step();
    end
    idle_inputs();
    @(negedge clock);
    n_cmp++; if (dut.u_cnt0.r_count !== 4'd2) begin n_err++; $display("FAIL rr_cnt0: got %0d want 2", dut.u_cnt0.r_count); end
    n_cmp++; if (dut.u_cnt1.r_count !== 4'd2) begin n_err++; $display("FAIL rr_cnt1: got %0d want 2", dut.u_cnt1.r_count); end
  endtask

  task automatic test_hold();
    logic [49:0] exp_bits;
    do_reset();
    s0_ar_bits = ar(4'h3, 32'h0000_1000, 8'd7);
    s1_ar_bits = ar(4'h9, 32'h0000_2000, 8'd2);
    exp_bits = {1'b0, s0_ar_bits};
    s0_ar_valid = 1'b1; s1_ar_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_ar_ready = (i == 3);
      @(negedge clock);
      n_cmp++; if (m_ar_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 1", i, m_ar_valid); end
      n_cmp++; if (m_ar_bits !== exp_bits) begin n_err++; $display("FAIL hold_bits[%0d]: got %h want %h", i, m_ar_bits, exp_bits); end
      n_cmp++; if (s1_ar_ready !== 1'b0) begin n_err++; $display("FAIL hold_s1_ready[%0d]: got %b want 0", i, s1_ar_ready); end
      n_cmp++; if (s0_ar_ready !== (i == 3)) begin n_err++; $display("FAIL hold_s0_ready[%0d]: got %b want %b", i, s0_ar_ready, (i == 3)); end
      step();
    end
    @(negedge clock);
    n_cmp++; if (m_ar_bits[49] !== 1'b1) begin n_err++; $display("FAIL hold_next_port: got %b want 1", m_ar_bits[49]); end
    n_cmp++; if (s1_ar_ready !== 1'b1) begin n_err++; $display("FAIL hold_next_s1_ready: got %b want 1", s1_ar_ready); end
    step();
    idle_inputs();
  endtask

  task automatic test_hold_drop();
    logic [49:0] exp_bits;
    do_reset();
    s0_ar_bits = ar(4'h6, 32'h0000_ABC0, 8'd2);
    exp_bits = {1'b0, s0_ar_bits};
    s0_ar_valid = 1'b1;
    step();
    s0_ar_valid = 1'b0;
    s0_ar_bits = '0;
    @(negedge clock);
    n_cmp++; if (m_ar_valid !== 1'b1) begin n_err++; $display("FAIL drop_valid: got %b want 1", m_ar_valid); end
    n_cmp++; if (m_ar_bits !== exp_bits) begin n_err++; $display("FAIL drop_bits: got %h want %h", m_ar_bits, exp_bits); end
    step();
    m_ar_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (s0_ar_ready !== 1'b1) begin n_err++; $display("FAIL drop_s0_ready: got %b want 1", s0_ar_ready); end
    step();
    idle_inputs();
    @(negedge clock);
    n_cmp++; if (m_ar_valid !== 1'b0) begin n_err++; $display("FAIL drop_after_valid: got %b want 0", m_ar_valid); end
    n_cmp++; if (dut.u_cnt0.r_count !== 4'd1) begin n_err++; $display("FAIL drop_cnt0: got %0d want 1", dut.u_cnt0.r_count); end
  endtask

  task automatic test_max_out();
    do_reset();
    s0_ar_bits = ar(4'h5, 32'h0000_3000, 8'd0);
    s1_ar_bits = ar(4'h7, 32'h0000_4000, 8'd0);
    s0_ar_valid = 1'b1; m_ar_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_cmp++; if (s0_ar_ready !== 1'b1) begin n_err++; $display("FAIL max_fill_ready[%0d]: got %b want 1", i, s0_ar_ready); end
      step();
    end
    s1_ar_valid = 1'b1;
    @(negedge clock);
    n_cmp++; if (s0_ar_ready !== 1'b0) begin n_err++; $display("FAIL max_s0_blocked: got %b want 0", s0_ar_ready); end
    n_cmp++; if (s1_ar_ready !== 1'b1) begin n_err++; $display("FAIL max_s1_granted: got %b want 1", s1_ar_ready); end
    n_cmp++; if (m_ar_bits[49] !== 1'b1) begin n_err++; $display("FAIL max_port: got %b want 1", m_ar_bits[49]); end
    step();
    s1_ar_valid = 1'b0;
    m_r_valid = 1'b1;
    m_r_bits = {5'h05, 64'h1111_2222_3333_4444, 2'b00, 1'b1};
    s0_r_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (s0_ar_ready !== 1'b0 || m_ar_valid !== 1'b0) begin n_err++; $display("FAIL max_still_blocked: got ready %b valid %b want 0 0", s0_ar_ready, m_ar_valid); end
    n_cmp++; if (s0_r_valid !== 1'b1 || m_r_ready !== 1'b1) begin n_err++; $display("FAIL max_r_route: got valid %b ready %b want 1 1", s0_r_valid, m_r_ready); end
    step();
    m_r_valid = 1'b0; s0_r_ready = 1'b0;
    @(negedge clock);
    n_cmp++; if (s0_ar_ready !== 1'b1) begin n_err++; $display("FAIL max_reopen: got %b want 1", s0_ar_ready); end
    step();
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    do_reset();
    s1_ar_bits = ar(4'h2, 32'h0000_5000, 8'd3);
    s1_ar_valid = 1'b1; m_ar_ready = 1'b1;
    step(); step(); step();
    m_r_valid = 1'b1;
    m_r_bits = {5'h12, 64'h5555_6666_7777_8888, 2'b00, 1'b1};
    s1_r_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (dut.u_cnt1.r_count !== 4'd3) begin n_err++; $display("FAIL same_pre_cnt1: got %0d want 3", dut.u_cnt1.r_count); end
    n_cmp++; if (s1_ar_ready !== 1'b1 || m_r_ready !== 1'b1) begin n_err++; $display("FAIL same_fires: got ar %b r %b want 1 1", s1_ar_ready, m_r_ready); end
    step();
    s1_ar_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (dut.u_cnt1.r_count !== 4'd3) begin n_err++; $display("FAIL same_cnt1: got %0d want 3", dut.u_cnt1.r_count); end
    step();
    idle_inputs();
    @(negedge clock);
    n_cmp++; if (dut.u_cnt1.r_count !== 4'd2) begin n_err++; $display("FAIL same_dec_cnt1: got %0d want 2", dut.u_cnt1.r_count); end
  endtask

  task automatic test_r_route();
    logic [70:0] exp_r;
    do_reset();
    m_r_valid = 1'b1;
    m_r_bits = {5'h1A, 64'hDEAD_BEEF_0123_4567, 2'b10, 1'b0};
    exp_r = {4'hA, 64'hDEAD_BEEF_0123_4567, 2'b10, 1'b0};
    s0_r_ready = 1'b1; s1_r_ready = 1'b0;
    #1;
    n_cmp++; if (s1_r_valid !== 1'b1 || s0_r_valid !== 1'b0) begin n_err++; $display("FAIL r_valid: got s1 %b s0 %b want 1 0", s1_r_valid, s0_r_valid); end
    n_cmp++; if (s1_r_bits !== exp_r) begin n_err++; $display("FAIL r_bits: got %h want %h", s1_r_bits, exp_r); end
    n_cmp++; if (m_r_ready !== 1'b0) begin n_err++; $display("FAIL r_ready_low: got %b want 0", m_r_ready); end
    s0_r_ready = 1'b0; s1_r_ready = 1'b1;
    #1;
    n_cmp++; if (m_r_ready !== 1'b1) begin n_err++; $display("FAIL r_ready_high: got %b want 1", m_r_ready); end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    s0_ar_bits = ar(4'h4, 32'h0000_6000, 8'd1);
    s1_ar_bits = ar(4'h8, 32'h0000_7000, 8'd1);
    s1_ar_valid = 1'b1; m_ar_ready = 1'b1;
    step(); step();
    s0_ar_valid = 1'b1; m_ar_ready = 1'b0;
    step();
    @(negedge clock);
    n_cmp++; if (m_ar_valid !== 1'b1 || m_ar_bits[49] !== 1'b0) begin n_err++; $display("FAIL rih_hold: got valid %b port %b want 1 0", m_ar_valid, m_ar_bits[49]); end
    m_ar_ready = 1'b1;
    reset = 1'b1;
    #1;
    n_cmp++; if (m_ar_valid !== 1'b0) begin n_err++; $display("FAIL rih_valid: got %b want 0", m_ar_valid); end
    n_cmp++; if (s0_ar_ready !== 1'b0) begin n_err++; $display("FAIL rih_ready: got %b want 0", s0_ar_ready); end
    n_cmp++; if (dut.u_cnt1.r_count !== 4'd0 || dut.u_cnt0.r_count !== 4'd0) begin n_err++; $display("FAIL rih_cnt: got %0d %0d want 0 0", dut.u_cnt0.r_count, dut.u_cnt1.r_count); end
    step();
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (m_ar_bits[49] !== 1'b0 || s0_ar_ready !== 1'b1) begin n_err++; $display("FAIL rih_first: got port %b ready %b want 0 1", m_ar_bits[49], s0_ar_ready); end
    step();
    idle_inputs();
    @(negedge clock);
    n_cmp++; if (dut.u_cnt0.r_count !== 4'd1) begin n_err++; $display("FAIL rih_cnt0_after: got %0d want 1", dut.u_cnt0.r_count); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_hold();
    test_hold_drop();
    test_max_out();
    test_same_cycle();
    test_r_route();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
